// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 default timing and a constant-evaluable clog2
// used to size the column and row buses.
package vga_timing_pkg;

  // 640x480@60 horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;

  // 640x480@60 vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Fetch lead in pixel clocks
  localparam int DEF_PREFETCH = 2;

  // Number of bits needed to hold values 0..value-1
  function automatic int clog2(input int value);
    int result;
    int pow;
    result = 0;
    pow    = 1;
    for (int i = 0; i < 31; i++) begin
      if (pow < value) begin
        result = result + 1;
        pow    = pow * 2;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical) of the timing generator.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   run        - low forces the axis back to 0 with idle sync
//   start      - load count 0 (first cycle after reset/enable rise)
//   step       - advance the count by one, wrapping at the axis total
//   count      - registered position on this axis
//   wrap       - count is at the last position (next step wraps to 0)
//   active     - the position being loaded at the next edge is visible;
//                the parent registers it together with the other axis
//   sync       - registered sync level for the current count
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FRONT    = DEF_H_FRONT,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BACK     = DEF_H_BACK,
  parameter bit POLARITY = 1'b0,
  parameter int W        = clog2(ACTIVE + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         start,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int          TOTAL    = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [31:0] ACT_END  = 32'(ACTIVE);
  localparam logic [31:0] SYNC_BEG = 32'(ACTIVE + FRONT);
  localparam logic [31:0] SYNC_END = 32'(ACTIVE + FRONT + SYNC);

  logic [W-1:0] count_r;
  logic [W-1:0] count_next_s;
  logic [31:0]  next_ext_s;
  logic         in_sync_s;
  logic         sync_r;

  // Next position on this axis: restart, advance with wrap, or hold
  always_comb begin
    count_next_s = count_r;
    if (start) begin
      count_next_s = {W{1'b0}};
    end else if (step) begin
      if (count_r == LAST) begin
        count_next_s = {W{1'b0}};
      end else begin
        count_next_s = count_r + W'(1'b1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Widened so the sync end bound cannot alias when it equals a power of two
  assign next_ext_s = 32'(count_next_s);
  assign in_sync_s  = (next_ext_s >= SYNC_BEG) && (next_ext_s < SYNC_END);

  // Count and sync registers; stopping drops straight to idle so no
  // partial sync pulse survives a reset or enable drop
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count_r <= {W{1'b0}};
      sync_r  <= ~POLARITY;
    end else begin
      count_r <= count_next_s;
      sync_r  <= in_sync_s ? POLARITY : ~POLARITY;
    end
  end

  assign count  = count_r;
  assign sync   = sync_r;
  assign wrap   = (count_r == LAST);
  assign active = (next_ext_s < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a leading fetch position.
// Ports:
//   clkDiv          - pixel clock (only clock, rising edge)
//   rst             - synchronous active-high reset, wins over enable
//   enable          - timing runs while high; low parks at reset values
//   hSync, vSync    - sync outputs at HSYNC_POL / VSYNC_POL when asserted
//   column, row     - current raster position (raw, also in blanking)
//   displayActive   - current position is in the visible area
//   lineStart       - one-cycle pulse at column 0
//   frameStart      - one-cycle pulse at (0,0)
//   fetchColumn/Row - position PREFETCH pixel clocks ahead
//   fetchValid      - that leading position is visible
//   frameCount      - completed frames, wraps 255 -> 0
// All outputs are registered and describe the same raster position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PREFETCH  = DEF_PREFETCH,
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int COL_W    = clog2(H_TOTAL),
  localparam int ROW_W    = clog2(V_TOTAL)
) (
  input  logic             clkDiv,
  input  logic             rst,
  input  logic             enable,
  output logic             hSync,
  output logic             vSync,
  output logic [COL_W-1:0] column,
  output logic [ROW_W-1:0] row,
  output logic             displayActive,
  output logic             lineStart,
  output logic             frameStart,
  output logic             fetchValid,
  output logic [COL_W-1:0] fetchColumn,
  output logic [ROW_W-1:0] fetchRow,
  output logic [7:0]       frameCount
);

  localparam logic [COL_W-1:0] H_LAST    = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_LAST    = ROW_W'(V_TOTAL - 1);
  localparam logic [COL_W-1:0] F_START   = COL_W'(PREFETCH);
  localparam logic [31:0]      H_ACT_LIM = 32'(H_ACTIVE);
  localparam logic [31:0]      V_ACT_LIM = 32'(V_ACTIVE);

  logic             running_r;
  logic             start_s;
  logic             h_wrap_s;
  logic             h_active_s;
  logic             v_wrap_s;
  logic             v_active_s;
  logic [COL_W-1:0] fetch_col_r;
  logic [COL_W-1:0] fetch_col_next_s;
  logic [ROW_W-1:0] fetch_row_r;
  logic [ROW_W-1:0] fetch_row_next_s;
  logic             fetch_valid_next_s;
  logic             fetch_valid_r;
  logic             display_active_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic [7:0]       frame_count_r;

  // The first running edge after reset or enable rise loads (0,0) rather
  // than advancing, so the outputs present the origin on that edge
  assign start_s = ~running_r;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POLARITY(HSYNC_POL), .W(COL_W)
  ) u_h_axis (
    .clk(clkDiv), .rst(rst), .run(enable), .start(start_s), .step(1'b1),
    .count(column), .wrap(h_wrap_s), .active(h_active_s), .sync(hSync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POLARITY(VSYNC_POL), .W(ROW_W)
  ) u_v_axis (
    .clk(clkDiv), .rst(rst), .run(enable), .start(start_s), .step(h_wrap_s),
    .count(row), .wrap(v_wrap_s), .active(v_active_s), .sync(vSync)
  );

  // Leading fetch counter pair: starts PREFETCH columns ahead on row 0
  // and then advances in lock-step, wrapping across lines and frames
  always_comb begin
    fetch_col_next_s = fetch_col_r;
    fetch_row_next_s = fetch_row_r;
    if (start_s) begin
      fetch_col_next_s = F_START;
      fetch_row_next_s = {ROW_W{1'b0}};
    end else if (fetch_col_r == H_LAST) begin
      fetch_col_next_s = {COL_W{1'b0}};
      if (fetch_row_r == V_LAST) begin
        fetch_row_next_s = {ROW_W{1'b0}};
      end else begin
        fetch_row_next_s = fetch_row_r + ROW_W'(1'b1);
      end
    end else begin
      fetch_col_next_s = fetch_col_r + COL_W'(1'b1);
      fetch_row_next_s = fetch_row_r;
    end
  end

  assign fetch_valid_next_s = (32'(fetch_col_next_s) < H_ACT_LIM) &&
                              (32'(fetch_row_next_s) < V_ACT_LIM);

  // Output registers, fetch pair and frame counter; frameCount survives
  // an enable drop and only steps on a real frame wrap (not on restart)
  always_ff @(posedge clkDiv) begin
    if (rst || !enable) begin
      running_r        <= 1'b0;
      fetch_col_r      <= {COL_W{1'b0}};
      fetch_row_r      <= {ROW_W{1'b0}};
      fetch_valid_r    <= 1'b0;
      display_active_r <= 1'b0;
      line_start_r     <= 1'b0;
      frame_start_r    <= 1'b0;
      frame_count_r    <= rst ? 8'd0 : frame_count_r;
    end else begin
      running_r        <= 1'b1;
      fetch_col_r      <= fetch_col_next_s;
      fetch_row_r      <= fetch_row_next_s;
      fetch_valid_r    <= fetch_valid_next_s;
      display_active_r <= h_active_s && v_active_s;
      line_start_r     <= start_s || h_wrap_s;
      frame_start_r    <= start_s || (h_wrap_s && v_wrap_s);
      if (running_r && h_wrap_s && v_wrap_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign fetchColumn   = fetch_col_r;
  assign fetchRow      = fetch_row_r;
  assign fetchValid    = fetch_valid_r;
  assign displayActive = display_active_r;
  assign lineStart     = line_start_r;
  assign frameStart    = frame_start_r;
  assign frameCount    = frame_count_r;

endmodule
